// File: rtl/countdown_display.sv
// countdown_display
//   Four-digit BCD countdown timer with a multiplexed seven-segment driver.
//   Both strobes from the board divider are used as clock enables on ClockIn.
//
// Ports
//   ClockIn            board clock (only clock)
//   ResetN             synchronous active-low reset
//   TickDekrementacja  one-cycle enable: decrement while RUNNING
//   TickWyswietlanie   one-cycle enable: advance the scanned digit
//   Load / LoadValue   load four BCD digits (nibbles > 9 clamp to 9), go STOPPED
//   Start / Stop       STOPPED -> RUNNING / RUNNING -> STOPPED
//   Segmenty           {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   Anody              one-hot digit enable, polarity per ANODE_ACTIVE_LOW
//   Running, Zero      registered status
//   Done               one-cycle pulse when a decrement reaches 0000
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_STOPPED  | count held; Start moves to RUNNING if count != 0
// ST_RUNNING  | count decrements on each TickDekrementacja
// ST_EXPIRED  | count reached 0000 by decrement; only Load exits

module countdown_display #(
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic        ClockIn,
  input  logic        ResetN,
  input  logic        TickDekrementacja,
  input  logic        TickWyswietlanie,
  input  logic        Load,
  input  logic [15:0] LoadValue,
  input  logic        Start,
  input  logic        Stop,
  output logic [6:0]  Segmenty,
  output logic [3:0]  Anody,
  output logic        Running,
  output logic        Zero,
  output logic        Done
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  // Active-low code for digit 0 and the matching anode pattern for digit 0;
  // these are the reset values of the display registers.
  localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW   ? 7'b1000000 : 7'b0111111;
  localparam logic [3:0] AN_RST  = ANODE_ACTIVE_LOW ? 4'b1110    : 4'b0001;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        running_q, running_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;

  logic [3:0]  digit_sel;
  logic [6:0]  seg_raw;
  logic [3:0]  an_onehot;

  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple-borrow BCD decrement: a zero digit wraps to 9 and borrows
  // from the next digit up.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; codes above 9 cannot occur after clamping
  // and are shown blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Load) begin
      cnt_d   = bcd_clamp(LoadValue);
      state_d = ST_STOPPED;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (!Stop && Start && (cnt_q != 16'h0000)) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (Stop) begin
            state_d = ST_STOPPED;
          end else if (TickDekrementacja) begin
            cnt_d = bcd_dec(cnt_q);
            if (cnt_d == 16'h0000) state_d = ST_EXPIRED;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == ST_RUNNING);
    zero_d    = (cnt_d == 16'h0000);
    // Load always lands in STOPPED, so Done can only come from a decrement.
    done_d    = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
  end

  // The display registers are driven from idx_q and cnt_q so anode and
  // segment data always move together, one edge after the index/count.
  always_comb begin
    idx_d     = idx_q + {1'b0, TickWyswietlanie};
    digit_sel = cnt_q[{idx_q, 2'b00} +: 4];
    seg_raw   = seg_code(digit_sel);
    an_onehot = 4'b0001 << idx_q;
    seg_d     = SEG_ACTIVE_LOW   ? seg_raw   : ~seg_raw;
    an_d      = ANODE_ACTIVE_LOW ? ~an_onehot : an_onehot;
  end

  always_ff @(posedge ClockIn) begin
    if (!ResetN) begin
      state_q   <= ST_STOPPED;
      cnt_q     <= 16'h0000;
      idx_q     <= 2'd0;
      seg_q     <= SEG_RST;
      an_q      <= AN_RST;
      running_q <= 1'b0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      running_q <= running_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
    end
  end

  assign Segmenty = seg_q;
  assign Anody    = an_q;
  assign Running  = running_q;
  assign Zero     = zero_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_countdown_display.sv
module tb_countdown_display;

  logic        clk;
  logic        rst_n;
  logic        tick_d, tick_w, load, start, stop;
  logic [15:0] load_val;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        running, zero, done;

  countdown_display #(.ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .ClockIn           (clk),
    .ResetN            (rst_n),
    .TickDekrementacja (tick_d),
    .TickWyswietlanie  (tick_w),
    .Load              (load),
    .LoadValue         (load_val),
    .Start             (start),
    .Stop              (stop),
    .Segmenty          (seg),
    .Anody             (an),
    .Running           (running),
    .Zero              (zero),
    .Done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: count as a plain decimal integer.
  int st_m  = 0;   // 0 stopped, 1 running, 2 expired
  int cnt_m = 0;
  int idx_m = 0;

  typedef struct {
    logic [2:0] rzd;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic        st, sp, td, tw;
    logic [2:0]  rzd;
    logic        scan;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [6:0] code_of(input int d);
    logic [6:0] c;
    case (d)
      0: c = 7'b1000000;  1: c = 7'b1111001;  2: c = 7'b0100100;
      3: c = 7'b0110000;  4: c = 7'b0011001;  5: c = 7'b0010010;
      6: c = 7'b0000010;  7: c = 7'b1111000;  8: c = 7'b0000000;
      default: c = 7'b0010000;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] a;
    case (i)
      0: a = 4'b1110;  1: a = 4'b1101;  2: a = 4'b1011;
      default: a = 4'b0111;
    endcase
    return a;
  endfunction

  function automatic int digit_of(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  task automatic model_step(input logic ld, input logic [15:0] lv, input logic st,
                            input logic sp, input logic td, input logic tw,
                            output logic [2:0] rzd);
    int prev;
    int d;
    int p;
    prev = st_m;
    if (tw) idx_m = (idx_m + 1) % 4;
    if (ld) begin
      cnt_m = 0;
      p = 1;
      for (int k = 0; k < 4; k++) begin
        d = int'(lv[k*4 +: 4]);
        if (d > 9) d = 9;
        cnt_m = cnt_m + d * p;
        p = p * 10;
      end
      st_m = 0;
    end else if (sp && st_m == 1) begin
      st_m = 0;
    end else if (st && st_m == 0) begin
      if (cnt_m != 0) st_m = 1;
    end else if (td && st_m == 1) begin
      cnt_m = cnt_m - 1;
      if (cnt_m == 0) st_m = 2;
    end
    rzd = {st_m == 1, cnt_m == 0, (prev != 2) && (st_m == 2)};
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic ld, input logic [15:0] lv, input logic st,
                      input logic sp, input logic td, input logic tw,
                      input logic use_tbl, input logic [2:0] tbl_rzd,
                      input string name);
    logic [2:0] m;
    exp_t e;
    exp_t got;
    model_step(ld, lv, st, sp, td, tw, m);
    e.rzd  = use_tbl ? tbl_rzd : m;
    e.name = name;
    load = ld; load_val = lv; start = st; stop = sp; tick_d = td; tick_w = tw;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0; tick_d = 1'b0; tick_w = 1'b0;
    got = sb.pop_front();
    chk({got.name, ".running"}, {15'd0, running}, {15'd0, got.rzd[2]});
    chk({got.name, ".zero"},    {15'd0, zero},    {15'd0, got.rzd[1]});
    chk({got.name, ".done"},    {15'd0, done},    {15'd0, got.rzd[0]});
  endtask

  // Four scan pulses, each followed by one idle cycle for the display register.
  task automatic scan_check(input string name);
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b0, {name, ".scan_tick"});
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, {name, ".scan_idle"});
      chk({name, ".anode"}, {12'd0, an},  {12'd0, an_of(idx_m)});
      chk({name, ".seg"},   {9'd0, seg},  {9'd0, code_of(digit_of(cnt_m, idx_m))});
    end
  endtask

  task automatic reset_check(input string name);
    chk({name, ".anode"},   {12'd0, an},     16'h000e);
    chk({name, ".seg"},     {9'd0, seg},     16'h0040);
    chk({name, ".running"}, {15'd0, running}, 16'h0000);
    chk({name, ".zero"},    {15'd0, zero},    16'h0001);
    chk({name, ".done"},    {15'd0, done},    16'h0000);
  endtask

  task automatic add(input logic ld, input logic [15:0] lv, input logic st, input logic sp,
                     input logic td, input logic tw, input logic [2:0] rzd,
                     input logic scan, input string name);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.td = td; v.tw = tw;
    v.rzd = rzd; v.scan = scan; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    // Expected {Running, Zero, Done} after the edge that samples each row.
    add(1, 16'h0012, 0, 0, 0, 0, 3'b000, 0, "load_0012");
    add(0, 16'h0000, 1, 0, 0, 0, 3'b100, 0, "start_0012");
    for (int i = 0; i < 11; i++) add(0, 16'h0, 0, 0, 1, 0, 3'b100, 0, "tick_down");
    add(0, 16'h0000, 0, 0, 1, 0, 3'b011, 0, "tick_to_zero");
    add(0, 16'h0000, 0, 0, 0, 0, 3'b010, 0, "done_one_cycle");
    add(0, 16'h0000, 1, 0, 0, 0, 3'b010, 0, "start_expired");
    add(0, 16'h0000, 0, 0, 1, 1, 3'b010, 0, "tick_expired");
    add(1, 16'h0005, 1, 0, 1, 0, 3'b000, 1, "load_over_start_tick");
    add(0, 16'h0000, 1, 0, 0, 0, 3'b100, 0, "start_0005");
    add(0, 16'h0000, 0, 1, 1, 0, 3'b000, 1, "stop_over_tick");
    add(0, 16'h0000, 0, 0, 1, 1, 3'b000, 0, "tick_stopped");
    add(1, 16'ha9f3, 0, 0, 0, 0, 3'b000, 1, "load_clamp");
    add(1, 16'h0000, 0, 0, 0, 0, 3'b010, 0, "load_zero");
    add(0, 16'h0000, 1, 0, 0, 0, 3'b010, 0, "start_zero");
    add(1, 16'h0002, 0, 0, 0, 0, 3'b000, 0, "load_0002");
    add(0, 16'h0000, 1, 0, 1, 0, 3'b100, 1, "start_tick_same");
    add(0, 16'h0000, 0, 0, 1, 0, 3'b100, 0, "tick_0001");
    add(0, 16'h0000, 0, 0, 1, 0, 3'b011, 0, "tick_0000");
    add(1, 16'h0003, 0, 0, 0, 0, 3'b000, 0, "load_from_expired");

    rst_n = 1'b0;
    load = 0; load_val = 0; start = 0; stop = 0; tick_d = 0; tick_w = 0;

    // Reset held for three cycles with random inputs.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      load = 1'($urandom); load_val = 16'($urandom); start = 1'($urandom);
      stop = 1'($urandom); tick_d = 1'($urandom); tick_w = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    reset_check("reset");
    rst_n = 1'b1;
    load = 0; start = 0; stop = 0; tick_d = 0; tick_w = 0;
    st_m = 0; cnt_m = 0; idx_m = 0;

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].td, tbl[i].tw,
           1'b1, tbl[i].rzd, tbl[i].name);
      if (tbl[i].scan) scan_check(tbl[i].name);
    end

    // Borrow across three digits: 1000 -> 0999.
    step(1, 16'h1000, 0, 0, 0, 0, 0, 3'b0, "borrow_load");
    step(0, 16'h0000, 1, 0, 0, 0, 0, 3'b0, "borrow_start");
    step(0, 16'h0000, 0, 0, 1, 0, 0, 3'b0, "borrow_tick");
    step(0, 16'h0000, 0, 1, 0, 0, 0, 3'b0, "borrow_stop");
    scan_check("borrow");

    // Reset in the middle of a run and mid-scan.
    step(1, 16'h0050, 0, 0, 0, 0, 0, 3'b0, "midrun_load");
    step(0, 16'h0000, 1, 0, 0, 0, 0, 3'b0, "midrun_start");
    for (int i = 0; i < 7; i++) step(0, 16'h0, 0, 0, 1, 0, 0, 3'b0, "midrun_tick");
    scan_check("midrun_0043");
    step(0, 16'h0000, 0, 0, 0, 1, 0, 3'b0, "midrun_scan");
    rst_n = 1'b0;
    load = 1'($urandom); load_val = 16'($urandom); start = 1'b1;
    stop = 1'b0; tick_d = 1'b1; tick_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_check("midrun_reset");
    rst_n = 1'b1;
    load = 0; start = 0; stop = 0; tick_d = 0; tick_w = 0;
    st_m = 0; cnt_m = 0; idx_m = 0;
    step(0, 16'h0000, 1, 0, 1, 0, 0, 3'b0, "after_reset_start");
    scan_check("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
